// File: rtl/sa_rdata_channel.sv
// sa_rdata_channel: slave-side AXI4 read-data return path.
// Routes each R burst from one slave to the master that issued the matching AR,
// using an in-order FIFO of {mst_id, ARLEN} pushed by this slave's AR channel.
// Optional macro SA_RDATA_LAST_CHECK_EN adds a sticky RLAST_err_o output that
// flags slave RLAST disagreeing with the expected beat count.
module sa_rdata_channel #(
  parameter int unsigned MST_AMT          = 3,
  parameter int unsigned OUTSTANDING_AMT  = 8,
  parameter int unsigned MST_ID_W         = $clog2(MST_AMT),
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned TRANS_DATA_LEN_W = 3
) (
  input  logic                            ACLK_i,
  input  logic                            ARESETn_i,
  input  logic [MST_ID_W-1:0]             AR_mst_id_i,
  input  logic [TRANS_DATA_LEN_W-1:0]     AR_AxLEN_i,
  input  logic                            AR_fifo_order_wr_en_i,
  output logic                            AR_stall_o,
  input  logic [DATA_WIDTH-1:0]           s_RDATA_i,
  input  logic [1:0]                      s_RRESP_i,
  input  logic                            s_RLAST_i,
  input  logic                            s_RVALID_i,
  output logic                            s_RREADY_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]   dsp_RDATA_o,
  output logic [2*MST_AMT-1:0]            dsp_RRESP_o,
  output logic [MST_AMT-1:0]              dsp_RLAST_o,
  output logic [MST_AMT-1:0]              dsp_RVALID_o,
`ifdef SA_RDATA_LAST_CHECK_EN
  output logic                            RLAST_err_o,
`endif
  input  logic [MST_AMT-1:0]              dsp_RREADY_i
);

  localparam int unsigned PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_AMT + 1);

  // Order FIFO storage and bookkeeping
  logic [MST_ID_W-1:0]         r_ord_id  [OUTSTANDING_AMT];
  logic [TRANS_DATA_LEN_W-1:0] r_ord_len [OUTSTANDING_AMT];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_ord_cnt;

  // Output slice and beat counter
  logic [DATA_WIDTH-1:0]       r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [MST_ID_W-1:0]         r_dst;
  logic                        r_vld;
  logic [TRANS_DATA_LEN_W-1:0] r_beat_cnt;

  logic                        w_empty;
  logic                        w_full;
  logic [MST_ID_W-1:0]         w_head_id;
  logic [TRANS_DATA_LEN_W-1:0] w_head_len;
  logic [MST_AMT-1:0]          w_dst_oh;
  logic                        w_dst_rdy;
  logic                        w_s_hs;
  logic                        w_beat_last;
  logic                        w_pop;
  logic                        w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_ord_cnt == '0);
  assign w_full     = (r_ord_cnt == CNT_W'(OUTSTANDING_AMT));
  assign w_head_id  = r_ord_id[r_rd_ptr];
  assign w_head_len = r_ord_len[r_rd_ptr];

  // One-hot decode of the held beat's destination master
  always_comb begin
    w_dst_oh = '0;
    for (int unsigned m = 0; m < MST_AMT; m++) begin
      w_dst_oh[m] = (r_dst == MST_ID_W'(m));
    end
  end

  assign w_dst_rdy   = |(w_dst_oh & dsp_RREADY_i);
  assign s_RREADY_o  = ~w_empty & (~r_vld | w_dst_rdy);
  assign w_s_hs      = s_RVALID_i & s_RREADY_o;
  assign w_beat_last = (r_beat_cnt == w_head_len);
  assign w_pop       = w_s_hs & w_beat_last;
  // A push that coincides with the final-beat pop reuses the freed slot, even when full
  assign w_push      = AR_fifo_order_wr_en_i & (~w_full | w_pop);
  assign AR_stall_o  = w_full;

  // Order FIFO payload write (no reset needed: entries are only read when valid)
  always_ff @(posedge ACLK_i) begin
    if (w_push) begin
      r_ord_id[r_wr_ptr]  <= AR_mst_id_i;
      r_ord_len[r_wr_ptr] <= AR_AxLEN_i;
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ord_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_ord_cnt <= r_ord_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_ord_cnt <= r_ord_cnt - CNT_W'(1);
    end
  end

  // Beat counter within the current burst; wraps to 0 on the final beat
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_beat_cnt <= '0;
    end else if (w_s_hs) begin
      r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + TRANS_DATA_LEN_W'(1);
    end
  end

  // Output pipeline slice: load on slave handshake, drain when destination accepts
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_data <= '0;
      r_resp <= '0;
      r_last <= 1'b0;
      r_dst  <= '0;
      r_vld  <= 1'b0;
    end else if (w_s_hs) begin
      r_data <= s_RDATA_i;
      r_resp <= s_RRESP_i;
      r_last <= w_beat_last;
      r_dst  <= w_head_id;
      r_vld  <= 1'b1;
    end else if (w_dst_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign dsp_RDATA_o  = {MST_AMT{r_data}};
  assign dsp_RRESP_o  = {MST_AMT{r_resp}};
  assign dsp_RVALID_o = {MST_AMT{r_vld}} & w_dst_oh;
  assign dsp_RLAST_o  = {MST_AMT{r_vld & r_last}} & w_dst_oh;

`ifdef SA_RDATA_LAST_CHECK_EN
  logic r_rlast_err;

  // Sticky flag: slave RLAST disagrees with the expected final beat
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_rlast_err <= 1'b0;
    end else if (w_s_hs && (s_RLAST_i != w_beat_last)) begin
      r_rlast_err <= 1'b1;
    end
  end

  assign RLAST_err_o = r_rlast_err;
`else
  logic w_unused_rlast;
  assign w_unused_rlast = s_RLAST_i;
`endif

endmodule

// File: tb/tb_sa_rdata_channel.sv
// Bench for sa_rdata_channel: directed bursts, a burst-level reference model
// compared against the DUT every cycle, and hand-computed literal expectations.
module tb_sa_rdata_channel;
  localparam int unsigned MST_AMT = 3;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned LW      = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [ID_W-1:0]         AR_mst_id_i = '0;
  logic [LW-1:0]           AR_AxLEN_i = '0;
  logic                    AR_fifo_order_wr_en_i = 1'b0;
  logic                    AR_stall_o;
  logic [DW-1:0]           s_RDATA_i = '0;
  logic [1:0]              s_RRESP_i = '0;
  logic                    s_RLAST_i = 1'b0;
  logic                    s_RVALID_i = 1'b0;
  logic                    s_RREADY_o;
  logic [DW*MST_AMT-1:0]   dsp_RDATA_o;
  logic [2*MST_AMT-1:0]    dsp_RRESP_o;
  logic [MST_AMT-1:0]      dsp_RLAST_o;
  logic [MST_AMT-1:0]      dsp_RVALID_o;
  logic [MST_AMT-1:0]      dsp_RREADY_i = '1;
`ifdef SA_RDATA_LAST_CHECK_EN
  logic                    RLAST_err_o;
`endif

  always #5 clk = ~clk;

  sa_rdata_channel #(
    .MST_AMT(MST_AMT), .OUTSTANDING_AMT(DEPTH), .MST_ID_W(ID_W),
    .DATA_WIDTH(DW), .TRANS_DATA_LEN_W(LW)
  ) dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .AR_mst_id_i(AR_mst_id_i), .AR_AxLEN_i(AR_AxLEN_i),
    .AR_fifo_order_wr_en_i(AR_fifo_order_wr_en_i), .AR_stall_o(AR_stall_o),
    .s_RDATA_i(s_RDATA_i), .s_RRESP_i(s_RRESP_i), .s_RLAST_i(s_RLAST_i),
    .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
    .dsp_RDATA_o(dsp_RDATA_o), .dsp_RRESP_o(dsp_RRESP_o),
    .dsp_RLAST_o(dsp_RLAST_o), .dsp_RVALID_o(dsp_RVALID_o),
`ifdef SA_RDATA_LAST_CHECK_EN
    .RLAST_err_o(RLAST_err_o),
`endif
    .dsp_RREADY_i(dsp_RREADY_i)
  );

  typedef struct packed { logic [ID_W-1:0] id; logic [LW-1:0] len; } burst_t;
  typedef struct packed { logic [ID_W-1:0] dst; logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;

  burst_t mq[$];      // outstanding bursts in AR order
  beat_t  expq[$];    // beats accepted from the slave, not yet delivered
  beat_t  got_q[$];   // beats delivered to masters
  int     got_cyc[$];
  int     mbeat = 0;  // beats already seen of the head burst
  int     n_chk = 0;
  int     n_pass = 0;
  int     cyc = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin : cmp
    logic [MST_AMT-1:0] exp_vld;
    beat_t  h;
    beat_t  nb;
    burst_t b;
    logic   exp_rdy;
    logic   popped;
    int     sz;
    if (!rst_n) begin
      mq.delete();
      expq.delete();
      mbeat = 0;
    end else begin
      exp_vld = '0;
      h = '0;
      if (expq.size() > 0) begin
        h = expq[0];
        exp_vld[h.dst] = 1'b1;
      end
      chk("rvalid", 64'(dsp_RVALID_o), 64'(exp_vld));
      chk("rlast", 64'(dsp_RLAST_o), (expq.size() > 0 && h.last) ? 64'(exp_vld) : 64'd0);
      if (expq.size() > 0) begin
        chk("rdata", 64'(dsp_RDATA_o[DW*int'(h.dst) +: DW]), 64'(h.data));
        chk("rresp", 64'(dsp_RRESP_o[2*int'(h.dst) +: 2]), 64'(h.resp));
      end
      chk("ar_stall", 64'(AR_stall_o), 64'(mq.size() == DEPTH));
      exp_rdy = (mq.size() != 0) && (expq.size() == 0 || dsp_RREADY_i[h.dst]);
      chk("s_rready", 64'(s_RREADY_o), 64'(exp_rdy));
      if (expq.size() > 0 && dsp_RREADY_i[h.dst]) begin
        got_q.push_back(h);
        got_cyc.push_back(cyc);
        void'(expq.pop_front());
      end
      sz = mq.size();
      popped = 1'b0;
      if (s_RVALID_i && s_RREADY_o && sz > 0) begin
        b = mq[0];
        nb.dst  = b.id;
        nb.data = s_RDATA_i;
        nb.resp = s_RRESP_i;
        nb.last = (mbeat == int'(b.len));
        expq.push_back(nb);
        if (nb.last) begin
          void'(mq.pop_front());
          mbeat = 0;
          popped = 1'b1;
        end else begin
          mbeat++;
        end
      end
      if (AR_fifo_order_wr_en_i && (sz < DEPTH || popped)) begin
        b.id  = AR_mst_id_i;
        b.len = AR_AxLEN_i;
        mq.push_back(b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int len);
    AR_fifo_order_wr_en_i = 1'b1;
    AR_mst_id_i = ID_W'(id);
    AR_AxLEN_i  = LW'(len);
    tick();
    AR_fifo_order_wr_en_i = 1'b0;
  endtask

  // Present one beat and hold it until the slave handshake completes
  task automatic beat(input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    int   t;
    logic done;
    s_RVALID_i = 1'b1;
    s_RDATA_i  = d;
    s_RRESP_i  = r;
    s_RLAST_i  = l;
    t = 0;
    done = 1'b0;
    while (!done && t < 50) begin
      @(negedge clk);
      done = s_RREADY_o;
      tick();
      t++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL beat_timeout: data %0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic idle();
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || mq.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    tick();
    chk("drain", 64'(expq.size() + mq.size()), 64'd0);
  endtask

  task automatic clear_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic chk_got(input string name, input int i, input int dst, input logic [DW-1:0] d, input logic l);
    if (i < got_q.size()) begin
      chk({name, "_dst"}, 64'(got_q[i].dst), 64'(dst));
      chk({name, "_data"}, 64'(got_q[i].data), 64'(d));
      chk({name, "_last"}, 64'(got_q[i].last), 64'(l));
    end
  endtask

  task automatic chk_back_to_back(input string name);
    for (int i = 1; i < got_cyc.size(); i++) chk(name, 64'(got_cyc[i] - got_cyc[i-1]), 64'd1);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_rvalid", 64'(dsp_RVALID_o), 64'd0);
    chk("rst_rdata", 64'(dsp_RDATA_o), 64'd0);
    chk("rst_rlast", 64'(dsp_RLAST_o), 64'd0);
    chk("rst_s_rready", 64'(s_RREADY_o), 64'd0);
    chk("rst_stall", 64'(AR_stall_o), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: single 4-beat burst to master 1
    clear_got();
    push(1, 3);
    for (int i = 0; i < 4; i++) beat(DW'(32'hA0 + i), 2'(i), i == 3);
    idle();
    wait_drain();
    chk("t1_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_got("t1", i, 1, DW'(32'hA0 + i), i == 3);
    chk_back_to_back("t1_gap");

    // 2: three bursts streamed, no bubbles at burst switches
    clear_got();
    push(0, 0);
    push(2, 1);
    push(1, 0);
    for (int i = 0; i < 4; i++) beat(DW'(32'hB0 + i), 2'b00, 1'b0);
    idle();
    wait_drain();
    chk("t2_count", 64'(got_q.size()), 64'd4);
    chk_got("t2_b0", 0, 0, 32'hB0, 1'b1);
    chk_got("t2_b1", 1, 2, 32'hB1, 1'b0);
    chk_got("t2_b2", 2, 2, 32'hB2, 1'b1);
    chk_got("t2_b3", 3, 1, 32'hB3, 1'b1);
    chk_back_to_back("t2_gap");

    // 3: destination back-pressure mid-burst
    clear_got();
    push(2, 3);
    fork
      begin
        for (int i = 0; i < 4; i++) beat(DW'(32'hC0 + i), 2'b10, i == 3);
        idle();
      end
      begin
        tick();
        tick();
        dsp_RREADY_i[2] = 1'b0;
        #1;
        chk("t3_s_rready_low", 64'(s_RREADY_o), 64'd0);
        chk("t3_held_vld", 64'(dsp_RVALID_o), 64'b100);
        repeat (5) tick();
        dsp_RREADY_i[2] = 1'b1;
      end
    join
    wait_drain();
    chk("t3_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_got("t3", i, 2, DW'(32'hC0 + i), i == 3);

    // 4: empty FIFO stalls the slave; full FIFO stalls AR
    clear_got();
    s_RVALID_i = 1'b1;
    s_RDATA_i = 32'hDEAD;
    tick();
    chk("t4_empty_rready", 64'(s_RREADY_o), 64'd0);
    idle();
    for (int i = 0; i < 8; i++) push(i % 3, 0);
    chk("t4_full_stall", 64'(AR_stall_o), 64'd1);
    push(0, 0);
    chk("t4_ignored_stall", 64'(AR_stall_o), 64'd1);
    AR_fifo_order_wr_en_i = 1'b1;
    AR_mst_id_i = 2'd2;
    AR_AxLEN_i = 3'd0;
    beat(32'hD0, 2'b01, 1'b1);
    AR_fifo_order_wr_en_i = 1'b0;
    idle();
    chk("t4_pushpop_stall", 64'(AR_stall_o), 64'd1);
    for (int i = 1; i < 9; i++) beat(DW'(32'hD0 + i), 2'b01, 1'b1);
    idle();
    wait_drain();
    chk("t4_count", 64'(got_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) chk_got("t4", i, i % 3, DW'(32'hD0 + i), 1'b1);
    chk("t4_end_stall", 64'(AR_stall_o), 64'd0);
    chk("t4_end_rready", 64'(s_RREADY_o), 64'd0);

    // 5: asynchronous reset mid-burst, then recovery
    push(2, 3);
    beat(32'hE0, 2'b00, 1'b0);
    beat(32'hE1, 2'b00, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 64'(dsp_RVALID_o), 64'd0);
    chk("t5_rst_rlast", 64'(dsp_RLAST_o), 64'd0);
    chk("t5_rst_rdata", 64'(dsp_RDATA_o), 64'd0);
    chk("t5_rst_rready", 64'(s_RREADY_o), 64'd0);
    chk("t5_rst_stall", 64'(AR_stall_o), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_got();
    push(0, 1);
    beat(32'hF0, 2'b11, 1'b0);
    beat(32'hF1, 2'b11, 1'b1);
    idle();
    wait_drain();
    chk("t5_count", 64'(got_q.size()), 64'd2);
    chk_got("t5_b0", 0, 0, 32'hF0, 1'b0);
    chk_got("t5_b1", 1, 0, 32'hF1, 1'b1);

`ifdef SA_RDATA_LAST_CHECK_EN
    // 6: early slave RLAST raises the sticky error; routing keeps its own count
    clear_got();
    chk("t6_err_init", 64'(RLAST_err_o), 64'd0);
    push(1, 3);
    beat(32'h60, 2'b00, 1'b0);
    beat(32'h61, 2'b00, 1'b1);
    chk("t6_err_set", 64'(RLAST_err_o), 64'd1);
    beat(32'h62, 2'b00, 1'b0);
    beat(32'h63, 2'b00, 1'b1);
    idle();
    wait_drain();
    chk("t6_err_sticky", 64'(RLAST_err_o), 64'd1);
    chk("t6_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_got("t6", i, 1, DW'(32'h60 + i), i == 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
